// File: rtl/reaction_fsm_pkg.sv
// Shared game-state encodings and constants for the reaction timer, its LED and display stages.
// Pure definitions: no latency, no flow control.
package reaction_fsm_pkg;

    typedef logic [2:0]  state_t;
    typedef logic [13:0] ms_t;

    localparam state_t STATE_IDLE        = 3'd0;
    localparam state_t STATE_PREP        = 3'd1;
    localparam state_t STATE_TEST        = 3'd2;
    localparam state_t STATE_RESULT_OK   = 3'd3;
    localparam state_t STATE_RESULT_FAIL = 3'd4;

    localparam ms_t         MS_MAX    = 14'h3FFF;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // x^16 + x^14 + x^13 + x^11 + 1, shifted left with feedback into bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/reaction_fsm_lfsr16.sv
// lfsr16: free-running 16-bit maximal-length LFSR, seeded with 16'hACE1 on reset.
// Advances every cycle, output registered; no flow control.
module lfsr16
    import reaction_fsm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = lfsr_next(q_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= LFSR_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/reaction_fsm.sv
// Reaction-time game FSM: random PREP delay, ms-resolution TEST timing, optional best-time tracking (HIGH_SCORE_EN).
// All outputs registered, 1-cycle latency from button pulse; inputs are single-cycle pulses, never stalled.
module reaction_fsm
    import reaction_fsm_pkg::*;
#(
    parameter int CLK_HZ         = 100000000,
    parameter int PREP_MIN_MS    = 1000,
    parameter int PREP_RAND_BITS = 11,
    parameter int TIMEOUT_MS     = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start,
    input  logic        btn_react,
    output logic [2:0]  current_state,
    output logic [13:0] reaction_ms,
    output logic        result_valid,
    output logic        is_high_score,
    output logic [13:0] best_ms
);

    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam int DLY_W = 16;
    localparam logic [DLY_W-1:0] DLY_ONE = DLY_W'(1);
    localparam ms_t MS_ONE    = 14'd1;
    localparam ms_t TIMEOUT_V = 14'(TIMEOUT_MS);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              ms_tick;
    logic [15:0]       lfsr_val;
    logic              lfsr_unused;
    logic [DLY_W-1:0]  delay_load;

    state_t           state_q, state_d;
    logic [DLY_W-1:0] delay_q, delay_d;
    ms_t              react_cnt_q, react_cnt_d;
    ms_t              react_inc;
    ms_t              reaction_q, reaction_d;
    logic             result_valid_q, result_valid_d;
    logic             go_prep, go_ok, go_fail;

    lfsr16 u_lfsr16 (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr_val)
    );

    // Only the low bits seed the PREP delay; the rest keep the LFSR period intact.
    assign lfsr_unused = ^lfsr_val;
    assign delay_load  = DLY_W'(PREP_MIN_MS) + DLY_W'(lfsr_val[PREP_RAND_BITS-1:0]);

    always_comb begin
        ms_tick    = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = ms_tick ? '0 : tick_cnt_q + TICK_ONE;
    end

    always_comb begin
        state_d     = state_q;
        delay_d     = delay_q;
        react_cnt_d = react_cnt_q;
        reaction_d  = reaction_q;
        go_prep     = 1'b0;
        go_ok       = 1'b0;
        go_fail     = 1'b0;
        react_inc   = (react_cnt_q == MS_MAX) ? react_cnt_q : react_cnt_q + MS_ONE;

        case (state_q)
            STATE_IDLE, STATE_RESULT_OK, STATE_RESULT_FAIL: begin
                if (btn_start) begin
                    state_d = STATE_PREP;
                    delay_d = delay_load;
                    go_prep = 1'b1;
                end
            end
            STATE_PREP: begin
                // A react pulse wins over a tick landing on the same edge.
                if (btn_react) begin
                    state_d    = STATE_RESULT_FAIL;
                    reaction_d = '0;
                    go_fail    = 1'b1;
                end else if (ms_tick) begin
                    if (delay_q <= DLY_ONE) begin
                        state_d     = STATE_TEST;
                        delay_d     = '0;
                        react_cnt_d = '0;
                    end else begin
                        delay_d = delay_q - DLY_ONE;
                    end
                end
            end
            STATE_TEST: begin
                // Latch the count held before this edge, so a press on a tick edge is not credited that tick.
                if (btn_react) begin
                    state_d    = STATE_RESULT_OK;
                    reaction_d = react_cnt_q;
                    go_ok      = 1'b1;
                end else if (ms_tick) begin
                    react_cnt_d = react_inc;
                    if (react_inc >= TIMEOUT_V) begin
                        state_d    = STATE_RESULT_FAIL;
                        reaction_d = TIMEOUT_V;
                        go_fail    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase

        result_valid_d = go_ok | go_fail;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q     <= '0;
            state_q        <= STATE_IDLE;
            delay_q        <= '0;
            react_cnt_q    <= '0;
            reaction_q     <= '0;
            result_valid_q <= 1'b0;
        end else begin
            tick_cnt_q     <= tick_cnt_d;
            state_q        <= state_d;
            delay_q        <= delay_d;
            react_cnt_q    <= react_cnt_d;
            reaction_q     <= reaction_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign current_state = state_q;
    assign reaction_ms   = reaction_q;
    assign result_valid  = result_valid_q;

`ifdef HIGH_SCORE_EN
    logic hs_q, hs_d;
    ms_t  best_q, best_d;

    always_comb begin
        hs_d   = hs_q;
        best_d = best_q;
        if (go_prep || go_fail) begin
            hs_d = 1'b0;
        end else if (go_ok) begin
            if (react_cnt_q < best_q) begin
                hs_d   = 1'b1;
                best_d = react_cnt_q;
            end else begin
                hs_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q   <= 1'b0;
            best_q <= MS_MAX;
        end else begin
            hs_q   <= hs_d;
            best_q <= best_d;
        end
    end

    assign is_high_score = hs_q;
    assign best_ms       = best_q;
`else
    assign is_high_score = 1'b0;
    assign best_ms       = MS_MAX;
`endif

endmodule
